// File: rtl/sdram_bridge_arbiter.sv
// Two-requester round-robin arbiter in front of a single SDRAM bridge port.
// One access at a time: IDLE -> ACCESS -> RELEASE -> IDLE, all outputs registered.
module sdram_bridge_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [26:0] m0_address,
  input  logic [1:0]  m0_byte_enable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [15:0] m0_write_data,
  output logic        m0_acknowledge,
  output logic [15:0] m0_read_data,
  output logic        m0_timeout,
  input  logic [26:0] m1_address,
  input  logic [1:0]  m1_byte_enable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [15:0] m1_write_data,
  output logic        m1_acknowledge,
  output logic [15:0] m1_read_data,
  output logic        m1_timeout,
  output logic [26:0] bridge_address,
  output logic [1:0]  bridge_byte_enable,
  output logic [15:0] bridge_write_data,
  output logic        bridge_read,
  output logic        bridge_write,
  input  logic        bridge_acknowledge,
  input  logic [15:0] bridge_read_data,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_cnt;

  logic        req0;
  logic        req1;
  logic        sel;
  logic [26:0] sel_address;
  logic [1:0]  sel_byte_enable;
  logic [15:0] sel_write_data;
  logic        sel_read;
  logic        sel_write;

  logic        done;
  logic        done_timeout;
  logic [15:0] done_data;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    req0            = m0_read | m0_write;
    req1            = m1_read | m1_write;
    sel             = (req0 && req1) ? ~grant : req1;
    sel_address     = m0_address;
    sel_byte_enable = m0_byte_enable;
    sel_write_data  = m0_write_data;
    sel_read        = m0_read;
    sel_write       = m0_write;
    if (sel) begin
      sel_address     = m1_address;
      sel_byte_enable = m1_byte_enable;
      sel_write_data  = m1_write_data;
      sel_read        = m1_read;
      sel_write       = m1_write;
    end
  end

  // Acknowledge beats a coincident timeout; writes and aborts return zero data.
  always_comb begin
    done_timeout = !bridge_acknowledge && (wait_cnt == WAIT_LAST);
    done         = bridge_acknowledge || done_timeout;
    done_data    = (bridge_acknowledge && bridge_read) ? bridge_read_data : 16'h0000;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      grant              <= 1'b1;
      busy               <= 1'b0;
      bridge_address     <= '0;
      bridge_byte_enable <= '0;
      bridge_write_data  <= '0;
      bridge_read        <= 1'b0;
      bridge_write       <= 1'b0;
      m0_acknowledge     <= 1'b0;
      m0_timeout         <= 1'b0;
      m0_read_data       <= '0;
      m1_acknowledge     <= 1'b0;
      m1_timeout         <= 1'b0;
      m1_read_data       <= '0;
    end else begin
      m0_acknowledge <= 1'b0;
      m0_timeout     <= 1'b0;
      m1_acknowledge <= 1'b0;
      m1_timeout     <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant              <= sel;
            bridge_address     <= sel_address;
            bridge_byte_enable <= sel_byte_enable;
            bridge_write_data  <= sel_write_data;
            bridge_write       <= sel_write;
            bridge_read        <= sel_read && !sel_write;
            wait_cnt           <= '0;
            busy               <= 1'b1;
            state              <= ACCESS;
          end
        end
        ACCESS: begin
          if (done) begin
            bridge_read  <= 1'b0;
            bridge_write <= 1'b0;
            if (!grant) begin
              m0_acknowledge <= 1'b1;
              m0_timeout     <= done_timeout;
              m0_read_data   <= done_data;
            end else begin
              m1_acknowledge <= 1'b1;
              m1_timeout     <= done_timeout;
              m1_read_data   <= done_data;
            end
            state <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
